// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter : shares one memory port between the I-cache and D-cache        |
// | controllers for BEATS-long bursts, tagging reads back to their issuer.      |
// | Optional: MEM_ARB_ROUND_ROBIN_EN (alternate on contention instead of D-first)|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int BEATS      = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              i_stall,
  output logic [DATA_W-1:0] i_data_out,
  output logic              i_data_valid,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data_in,
  output logic              d_stall,
  output logic [DATA_W-1:0] d_data_out,
  output logic              d_data_valid,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_stall,
  input  logic              mem_err,
  output logic [1:0]        grant,
  output logic              err
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_I = 2'b01,
    OWN_D = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RD_LATENCY-1:0]   tag_vld_q;
  logic [RD_LATENCY-1:0]   tag_own_q;  // 1 = read belongs to D

  logic              i_req, d_req, owned, own_is_d;
  logic              own_rd, own_wr, illegal, abort, beat_acc, rd_push, pick_d;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;

  assign i_req = i_rd | i_wr;
  assign d_req = d_rd | d_wr;

  always_comb begin
    own_rd    = 1'b0;
    own_wr    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    own_is_d  = 1'b0;
    case (state_q)
      OWN_I: begin
        own_rd    = i_rd;
        own_wr    = i_wr;
        own_addr  = i_addr;
        own_wdata = i_data_in;
      end
      OWN_D: begin
        own_rd    = d_rd;
        own_wr    = d_wr;
        own_addr  = d_addr;
        own_wdata = d_data_in;
        own_is_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign owned    = (state_q != IDLE);
  assign illegal  = owned & own_rd & own_wr;
  assign abort    = owned & ~own_rd & ~own_wr;
  assign beat_acc = owned & (own_rd ^ own_wr) & ~mem_stall;
  assign rd_push  = beat_acc & own_rd;

  assign mem_rd      = own_rd & ~illegal;
  assign mem_wr      = own_wr & ~illegal;
  assign mem_addr    = own_addr;
  assign mem_data_in = own_wdata;

  assign i_stall = (state_q == OWN_I) ? (mem_stall | illegal) : i_req;
  assign d_stall = (state_q == OWN_D) ? (mem_stall | illegal) : d_req;

  assign grant = {state_q == OWN_D, state_q == OWN_I};
  assign err   = illegal | mem_err;

  assign i_data_out = mem_data_out;
  assign d_data_out = mem_data_out;
  // Reset discards in-flight tags in the same cycle it is asserted.
  assign i_data_valid = tag_vld_q[RD_LATENCY-1] & ~tag_own_q[RD_LATENCY-1] & ~rst;
  assign d_data_valid = tag_vld_q[RD_LATENCY-1] &  tag_own_q[RD_LATENCY-1] & ~rst;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q;
  assign pick_d = d_req & (~i_req | ~last_d_q);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_d)     state_d = OWN_D;
        else if (i_req) state_d = OWN_I;
      end
      default: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (beat_acc) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tag_vld_q <= '0;
      tag_own_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tag_vld_q[0] <= rd_push;
      tag_own_q[0] <= own_is_d;
      for (int k = 1; k < RD_LATENCY; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_own_q[k] <= tag_own_q[k-1];
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (state_q == IDLE && state_d != IDLE) last_d_q <= (state_d == OWN_D);
`endif
    end
  end

endmodule
`default_nettype wire
